// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_P = 1'b0,
    GNT_L = 1'b1
  } gnt_t;

  // RISC-V style load/store size encodings carried on FUNC3
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Loader traffic is always a full word
  localparam logic [2:0] LOADER_FUNC3 = LW;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (f3[1:0] == LH[1:0])      m = a[0];
    else if (f3[1:0] == LW[1:0]) m = (a != 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins, a tie goes to the
// side that was not granted last. History starts as "loader" so the first
// tie after reset goes to the pipeline.
module dmem_rr_arb2 import dmem_access_ctrl_pkg::*; (
  input  logic CLK,
  input  logic RST,
  input  logic i_req_p,
  input  logic i_req_l,
  input  logic i_update,
  output logic o_gnt
);

  gnt_t r_last;
  gnt_t w_gnt;

  // Winner selection
  always_comb begin
    w_gnt = GNT_P;
    if (i_req_p && i_req_l) w_gnt = (r_last == GNT_P) ? GNT_L : GNT_P;
    else if (i_req_l)       w_gnt = GNT_L;
  end

  // Remember who was granted last
  always_ff @(posedge CLK) begin
    if (RST)           r_last <= GNT_L;
    else if (i_update) r_last <= w_gnt;
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer + pipeline/loader arbiter.
// Optional build macro DMEM_MISALIGN_CHECK_EN adds misaligned-access
// detection for the pipeline port (P_MISALIGN) and word-aligns loader addresses.
module dmem_access_ctrl import dmem_access_ctrl_pkg::*; #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              P_REQ,
  input  logic              P_WRITE,
  input  logic [ADDR_W-1:0] P_ADDR,
  input  logic [31:0]       P_WDATA,
  input  logic [2:0]        P_FUNC3,
  output logic [31:0]       P_RDATA,
  output logic              P_STALL,
`ifdef DMEM_MISALIGN_CHECK_EN
  output logic              P_MISALIGN,
`endif
  input  logic              L_REQ,
  input  logic              L_WRITE,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [31:0]       L_WDATA,
  output logic              L_ACK,
  output logic [31:0]       L_RDATA,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  output logic [2:0]        M_FUNC3,
  output logic              M_WRITE,
  output logic              M_READ,
  input  logic [31:0]       M_RDATA
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            r_state, w_next;
  logic [3:0]        r_count;
  logic              r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_func3;
  logic              r_write;
  logic [31:0]       r_p_rdata, r_l_rdata;

  logic              w_arb_gnt;
  logic              w_start;
  logic              w_mis;
  logic [ADDR_W-1:0] w_l_addr;

  assign w_start = (r_state == IDLE) && (P_REQ || L_REQ);

  dmem_rr_arb2 u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .i_req_p  (P_REQ),
    .i_req_l  (L_REQ),
    .i_update (w_start),
    .o_gnt    (w_arb_gnt)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_mis    = w_start && (w_arb_gnt == GNT_P) && is_misaligned(P_FUNC3, P_ADDR[1:0]);
  assign w_l_addr = {L_ADDR[ADDR_W-1:2], 2'b00};

  // Flag is high only in the DONE cycle that follows a rejected request
  always_ff @(posedge CLK) begin
    if (RST) r_misalign <= 1'b0;
    else     r_misalign <= w_mis;
  end
  assign P_MISALIGN = r_misalign;
`else
  assign w_mis    = 1'b0;
  assign w_l_addr = L_ADDR;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: misaligned pipeline requests skip straight to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_mis ? DONE : BUSY;
      BUSY:    if (r_count == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the granted request, run the latency counter, capture read data
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count   <= 4'd0;
      r_gnt     <= GNT_P;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_func3   <= 3'b000;
      r_write   <= 1'b0;
      r_p_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      if (w_start) begin
        r_gnt   <= w_arb_gnt;
        r_count <= LAT_M1;
        if (w_arb_gnt == GNT_P) begin
          r_addr  <= P_ADDR;
          r_wdata <= P_WDATA;
          r_func3 <= P_FUNC3;
          r_write <= P_WRITE;
        end else begin
          r_addr  <= w_l_addr;
          r_wdata <= L_WDATA;
          r_func3 <= LOADER_FUNC3;
          r_write <= L_WRITE;
        end
      end else if (r_state == BUSY && r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end
      if (r_state == BUSY && r_count == 4'd0 && !r_write) begin
        if (r_gnt == GNT_P) r_p_rdata <= M_RDATA;
        else                r_l_rdata <= M_RDATA;
      end
    end
  end

  assign M_ADDR  = r_addr;
  assign M_WDATA = r_wdata;
  assign M_FUNC3 = r_func3;
  assign M_READ  = (r_state == BUSY) && !r_write;
  assign M_WRITE = (r_state == BUSY) &&  r_write;
  assign L_ACK   = (r_state == DONE) && (r_gnt == GNT_L);
  assign L_RDATA = r_l_rdata;
  assign P_RDATA = r_p_rdata;
  // Stall follows P_REQ immediately; only the pipeline's own DONE releases it
  assign P_STALL = P_REQ && !((r_state == DONE) && (r_gnt == GNT_P));

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle access sequencer and two-way arbiter for the single-port data memory.
- Requesters:
  - Pipeline MEM stage (port P): byte, half and word accesses selected by FUNC3.
  - Program loader/debug port (port L): word-only accesses.
- Latches the granted request and drives the memory strobes for a fixed LATENCY.
- Stalls the pipeline until its access completes, and returns read data to the requester that was granted.

Parameters:
- LATENCY, 2, memory cycles from strobe assertion to valid M_RDATA; legal range 1..15.
- ADDR_W, 32, address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- P_REQ  in  1  pipeline request; held until P_STALL falls.
- P_WRITE  in  1  1 = store, 0 = load.
- P_ADDR  in  ADDR_W  pipeline address.
- P_WDATA  in  32  store data.
- P_FUNC3  in  3  access size/sign, passed to the memory.
- P_RDATA  out  32  load data; valid in the DONE cycle.
- P_STALL  out  1  freeze the pipeline.
- L_REQ  in  1  loader request; held until L_ACK.
- L_WRITE  in  1  loader store/load.
- L_ADDR  in  ADDR_W  loader address.
- L_WDATA  in  32  loader store data.
- L_ACK  out  1  one-cycle completion pulse.
- L_RDATA  out  32  loader read data; valid while L_ACK is high.
- M_ADDR  out  ADDR_W  memory address.
- M_WDATA  out  32  memory write data.
- M_FUNC3  out  3  memory access size.
- M_WRITE  out  1  write strobe.
- M_READ  out  1  read strobe.
- M_RDATA  in  32  memory read data.

Behaviour:
- Reset values (all registered outputs): every output 0, state IDLE, count 0, last_grant = L.
- State IDLE:
  - No strobes are driven.
  - If P_REQ or L_REQ is high, grant one requester, latch its addr/wdata/func3/write (loader func3 forced to 3'b010), load count = LATENCY-1, go BUSY.
- Arbitration:
  - A single requester always wins.
  - If both request, the winner is the requester that is not last_grant.
  - last_grant updates on every grant.
  - The first tie after reset goes to P.
- State BUSY:
  - M_ADDR, M_WDATA and M_FUNC3 come from the latched copy.
  - Exactly one of M_WRITE or M_READ is high for LATENCY consecutive cycles.
  - count decrements each cycle.
  - At count == 0: on a read, capture M_RDATA into the granted RDATA register; go DONE.
- State DONE:
  - Strobes are low.
  - Grant P: P_STALL is low this cycle.
  - Grant L: L_ACK = 1 this cycle.
  - Next state is IDLE.
  - Access length: LATENCY+1 cycles from grant to DONE; IDLE→IDLE round trip is LATENCY+2 cycles.
- P_STALL:
  - Combinational: P_REQ && !(state==DONE && grant==P).
  - Rises in the same cycle P_REQ appears, including while L is being served.
- RDATA on writes: P_RDATA and L_RDATA keep their previous values.
- Request inputs are sampled only in IDLE. Changes during BUSY/DONE are ignored, and a request dropped early is still completed.
- Both requests arriving in the same IDLE cycle: a single grant is issued; the loser waits, and P stays stalled.
- Requests are never lost. The loser is granted on the next IDLE cycle, and alternation prevents starvation.
- RST asserted mid-access: on that edge the block returns to IDLE, strobes drop, and no ack or RDATA update occurs. The interrupted write may be partial; software must reissue it.
- count width is 4 bits; LATENCY=1 gives a single BUSY cycle.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- With the macro:
  - Added output P_MISALIGN (1 bit, registered, reset 0).
  - A P request is misaligned when it is a half access with addr[0] != 0, or a word access with addr[1:0] != 0.
  - A misaligned request skips BUSY (no strobes) and goes IDLE→DONE. P_MISALIGN = 1 in that DONE cycle only, and P_RDATA is unchanged.
  - Loader addresses with addr[1:0] != 0 are aligned down, never flagged.
- Without the macro: the port is absent and addresses pass unchecked.

Decomposition:
- Shared package:
  - State enum: IDLE, BUSY, DONE.
  - Grant encodings: GNT_P, GNT_L.
  - FUNC3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - LOADER_FUNC3 = 3'b010.
- Sub-module dmem_rr_arb2: two-input round-robin arbiter holding last_grant.

Test Plan:
- LATENCY=2, P read addr 0x40, M_RDATA 0xDEADBEEF → M_READ high 2 cycles, DONE in cycle 3, P_RDATA = 0xDEADBEEF, P_STALL high cycles 0-2 and low in cycle 3.
- P and L request in the same cycle after reset → P served first; L granted at the next IDLE; L_ACK at cycle 3 + 4 = 7.
- P_REQ held continuously, L_REQ pulsed and held → grants alternate P, L, P; neither side waits more than one access.
- RST during the 2nd BUSY cycle of an L write 0x1234 → M_WRITE drops at that edge; no L_ACK; IDLE next cycle.
- LATENCY=1, P store SB addr 0x3 data 0xAB → M_WRITE for 1 cycle with M_FUNC3 = 000; P_RDATA unchanged.
- With DMEM_MISALIGN_CHECK_EN, P LW at 0x102 → no strobes; P_MISALIGN = 1 in cycle 1; stall released in cycle 1.
